// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Contents:
//   - standard timing sets (640x480@60, 800x600@60)
//   - sync polarity constants POL_NEG / POL_POS
//   - DELAY_MAX, the deepest supported output delay line
//   - max2(), used for the counter width check
package vga_timing_pkg;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  localparam int unsigned DELAY_MAX = 8;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs negative
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FRONT  = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BACK   = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FRONT  = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BACK   = 33;
  localparam logic        VGA640_H_POL    = POL_NEG;
  localparam logic        VGA640_V_POL    = POL_NEG;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs positive
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FRONT  = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BACK   = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FRONT  = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BACK   = 23;
  localparam logic        SVGA800_H_POL    = POL_POS;
  localparam logic        SVGA800_V_POL    = POL_POS;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x Depth shift register with a common advance enable.
// Every stage resets asynchronously to IdleVal. Depth = 0 is a plain wire.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset
//   en_i   - advance all stages by one
//   d_i    - input word
//   q_o    - word from the last stage (or d_i when Depth = 0)
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned       Width   = 1,
  parameter int unsigned       Depth   = 0,
  parameter logic [Width-1:0]  IdleVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth > DELAY_MAX) begin : g_depth_err
    $error("vga_delay_line: Depth exceeds DELAY_MAX");
  end

  if (Depth == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= IdleVal;
        end
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator running from the system clock
// with a pixel-rate enable. Produces x/y position, syncs, display enable and
// line/frame start strobes, all optionally delayed by DELAY enabled pixels.
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit frame counter.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-high reset
//   pix_en       - pixel enable; raster advances one pixel per enabled cycle
//   x, y         - current column / line
//   h_sync       - horizontal sync, active level H_POL
//   v_sync       - vertical sync, active level V_POL
//   disp         - inside the active area
//   line_start   - x == 0
//   frame_start  - x == 0 and y == 0
//   frame_cnt    - frames completed (VGA_FRAME_CNT_EN only)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = 10,
  parameter int unsigned DELAY    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          disp,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam longint unsigned CntRange = 64'd1 << CW;

  if (CntRange <= 64'(max2(H_TOTAL, V_TOTAL))) begin : g_cw_err
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (DELAY > DELAY_MAX) begin : g_delay_err
    $error("vga_timing_gen: DELAY exceeds DELAY_MAX");
  end

  localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HSyncEnd = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VSyncBeg = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VSyncEnd = CW'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_FRAME_CNT_EN
  localparam int unsigned BW = 2 * CW + 5 + 16;
`else
  localparam int unsigned BW = 2 * CW + 5;
`endif

  // Idle bundle held by the delay stages out of reset: syncs inactive, all else 0
  localparam logic [BW-1:0] IdleBundle = {
`ifdef VGA_FRAME_CNT_EN
    16'd0,
`endif
    {(2 * CW){1'b0}}, ~H_POL, ~V_POL, 3'b000
  };

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          wrap;

  assign wrap = (hc_q == HLast) && (vc_q == VLast);

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  // Counts on the enabled cycle that takes the raster from the last pixel to (0,0)
  always_comb begin
    fc_d = fc_q;
    if (pix_en && wrap) begin
      fc_d = fc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

  logic hs_act, vs_act;
  logic hs_lvl, vs_lvl, disp_raw, ls_raw, fs_raw;

  always_comb begin
    hs_act   = (hc_q >= HSyncBeg) && (hc_q < HSyncEnd);
    vs_act   = (vc_q >= VSyncBeg) && (vc_q < VSyncEnd);
    hs_lvl   = hs_act ? H_POL : ~H_POL;
    vs_lvl   = vs_act ? V_POL : ~V_POL;
    disp_raw = (hc_q < HActive) && (vc_q < VActive);
    ls_raw   = (hc_q == '0);
    fs_raw   = (hc_q == '0) && (vc_q == '0);
  end

  logic [BW-1:0] bundle_d, bundle_q;

  assign bundle_d = {
`ifdef VGA_FRAME_CNT_EN
    fc_q,
`endif
    hc_q, vc_q, hs_lvl, vs_lvl, disp_raw, ls_raw, fs_raw
  };

  vga_delay_line #(
    .Width   (BW),
    .Depth   (DELAY),
    .IdleVal (IdleBundle)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en_i (pix_en),
    .d_i  (bundle_d),
    .q_o  (bundle_q)
  );

  assign {
`ifdef VGA_FRAME_CNT_EN
    frame_cnt,
`endif
    x, y, h_sync, v_sync, disp, line_start, frame_start
  } = bundle_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the team's fixed 640x480 sync generator.
- Adds the following:
  - Fully parametrised porch/sync/active timing.
  - Selectable sync polarity.
  - Pixel clock enable, so the block runs from the system clock.
  - Asynchronous reset.
  - Line and frame start strobes.
  - A configurable output delay line that aligns timing with downstream pixel-data pipeline latency.
- Sits between the clock domain and the pixel renderer (snake game draw logic) and drives the VGA connector sync pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_POL, 0, vsync active level
CW, 10, width of x/y counters and outputs
DELAY, 0, output pipeline stages (0..8) applied to all outputs

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pix_en  input  1  pixel-rate enable; the raster advances one pixel per cycle with pix_en=1
x  output  CW  current pixel column (0..H_TOTAL-1)
y  output  CW  current line (0..V_TOTAL-1)
h_sync  output  1  horizontal sync, polarity per H_POL
v_sync  output  1  vertical sync, polarity per V_POL
disp  output  1  high inside the active area
line_start  output  1  high while x==0
frame_start  output  1  high while x==0 and y==0
frame_cnt  output  16  frames completed (present only with VGA_FRAME_CNT_EN)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Width check: elaboration fails if 2^CW <= max(H_TOTAL, V_TOTAL), or if DELAY > 8.
- Counters hc, vc, reset to 0. On a clk edge with pix_en=1:
  - If hc == H_TOTAL-1: hc <= 0, and vc <= (vc == V_TOTAL-1) ? 0 : vc+1.
  - Otherwise hc <= hc+1.
- pix_en=0: all state holds, including every delay stage.
- Decode from (hc, vc):
  - hs_act = hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vs_act = vc in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
  - h_sync = hs_act ? H_POL : ~H_POL; v_sync likewise with V_POL.
  - disp = hc < H_ACTIVE && vc < V_ACTIVE.
- DELAY=0: outputs are the counters plus combinational decode. After reset this gives x=0, y=0, disp=1, line_start=1, frame_start=1, syncs inactive.
- DELAY=N>0: the full output bundle passes through N registers, each advancing only on pix_en=1. Latency is N pix_en pulses.
  - Stages reset to the idle bundle: x=0, y=0, disp=0, line_start=0, frame_start=0, syncs at inactive level.
  - After reset, the first N enabled pixels output the idle bundle, then (0,0).
- Strobes: line_start and frame_start stay high for exactly one pixel period (one pix_en pulse interval), not one clk cycle.
- Reset mid-frame: counters and all stages return to reset values immediately (asynchronous). Counting restarts at (0,0) on the first pix_en after rst deasserts.
- Wrap boundary: (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0). No extra cycle is inserted.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: a 16-bit frame_cnt port exists.
  - Reset value 0.
  - Increments on the pix_en cycle where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Wraps 0xFFFF -> 0.
  - Delayed with the rest of the bundle.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - Localparam timing sets for 640x480@60 and 800x600@60 (porch/sync/active values).
  - A polarity constant POL_NEG=0 / POL_POS=1.
  - A DELAY_MAX=8 constant.
- Sub-module vga_delay_line: a parametrised width × depth shift register with enable and asynchronous reset to a supplied idle value. It is instantiated once for the packed output bundle.

Test Plan:
- Defaults, pix_en=1, 1000 cycles from reset:
  - h_sync=0 exactly for x=656..751.
  - line_start=1 at x=0 only.
  - x wraps 799->0 with y incrementing.
- Full frame run:
  - v_sync=0 exactly for y=490..491.
  - disp=1 exactly for 640x480 pixels per frame.
  - frame_start pulses once per 420000 enabled cycles at (0,0).
- pix_en=1 every 4th clk: x advances by 1 per pulse and holds otherwise; line_start stays high for 4 clk cycles.
- DELAY=3, H_POL=1, V_POL=1:
  - Outputs match the DELAY=0 reference model shifted by 3 pix_en pulses.
  - Syncs are high in the sync windows.
  - The first 3 pixels after reset show the idle bundle.
- Reset asserted at (x=300, y=200) between clock edges:
  - Outputs go to reset values without waiting for a clk edge.
  - The first enabled pixel after release is (0,0).
- VGA_FRAME_CNT_EN, small parameters (H 4/1/1/1, V 3/1/1/1), run 5 frames: frame_cnt reads 5 at the sixth frame_start.
